dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl_if.sv | 26 ++
 rtl/dds_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - sweep control/config inputs and frequency word outputs
interface dds_sweep_ctrl_if #(
  parameter int NSTEP_W = 16
);
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [31:0]        start_ftw;
  logic [31:0]        step_ftw;
  logic [NSTEP_W-1:0] num_steps;
  logic [19:0]        dwell;
  logic [31:0]        ftw_out;
  logic               step_stb;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, start_ftw, step_ftw, num_steps, dwell,
    input  ftw_out, step_stb, busy, done
  );

  modport slave (
    input  start, stop, mode, start_ftw, step_ftw, num_steps, dwell,
    output ftw_out, step_stb, busy, done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency sweep sequencer (single, sawtooth, triangle)
module dds_sweep_ctrl #(
  parameter int MIN_DWELL = 660,
  parameter int NSTEP_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dds_sweep_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  localparam logic [19:0]        MIN_D   = 20'(MIN_DWELL);
  localparam logic [NSTEP_W-1:0] IDX_ONE = NSTEP_W'(1);

  state_t             state_q, state_d;
  logic [NSTEP_W-1:0] idx_q, idx_d;
  logic [19:0]        cnt_q, cnt_d;
  logic [31:0]        ftw_q, ftw_d;
  logic               stb_q, stb_d;
  logic               up_q, up_d;
  logic               load;
  logic               go_up;

  logic [1:0]         mode_q;
  logic [31:0]        start_q, step_q;
  logic [NSTEP_W-1:0] nsteps_q;
  logic [19:0]        dwell_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ftw_q   <= '0;
      stb_q   <= 1'b0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ftw_q   <= ftw_d;
      stb_q   <= stb_d;
      up_q    <= up_d;
    end
  end

  // Configuration is reloaded on every accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      mode_q   <= bus.mode;
      start_q  <= bus.start_ftw;
      step_q   <= bus.step_ftw;
      nsteps_q <= bus.num_steps;
      dwell_q  <= (bus.dwell < MIN_D) ? MIN_D : bus.dwell;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ftw_d   = ftw_q;
    stb_d   = 1'b0;
    up_d    = up_q;
    load    = 1'b0;
    go_up   = up_q ? (idx_q != nsteps_q) : (idx_q == '0);
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          load    = 1'b1;
          state_d = RUN;
          ftw_d   = bus.start_ftw;
          idx_d   = '0;
          cnt_d   = 20'd1;
          stb_d   = 1'b1;
          up_d    = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < dwell_q) begin
          cnt_d = cnt_q + 20'd1;
        end else begin
          // Dwell expired: cnt restarts even when the word is held (num_steps=0 repeat modes).
          cnt_d = 20'd1;
          if (mode_q == 2'd1) begin
            if (nsteps_q != '0) begin
              stb_d = 1'b1;
              if (idx_q == nsteps_q) begin
                idx_d = '0;
                ftw_d = start_q;
              end else begin
                idx_d = idx_q + IDX_ONE;
                ftw_d = ftw_q + step_q;
              end
            end
          end else if (mode_q == 2'd2) begin
            if (nsteps_q != '0) begin
              stb_d = 1'b1;
              up_d  = go_up;
              if (go_up) begin
                idx_d = idx_q + IDX_ONE;
                ftw_d = ftw_q + step_q;
              end else begin
                idx_d = idx_q - IDX_ONE;
                ftw_d = ftw_q - step_q;
              end
            end
          end else begin
            if (idx_q == nsteps_q) begin
              state_d = FINISH;
              cnt_d   = '0;
            end else begin
              stb_d = 1'b1;
              idx_d = idx_q + IDX_ONE;
              ftw_d = ftw_q + step_q;
            end
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ftw_out  = ftw_q;
  assign bus.step_stb = stb_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == FINISH);
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - randomized and directed checks of dds_sweep_ctrl against a sequence model
module tb_dds_sweep_ctrl;
  localparam int MIN_DWELL = 660;
  localparam int NSTEP_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dds_sweep_ctrl_if #(.NSTEP_W(NSTEP_W)) bus ();

  dds_sweep_ctrl #(.MIN_DWELL(MIN_DWELL), .NSTEP_W(NSTEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          m_mode, m_n, m_d;
  logic [31:0] m_s, m_st;
  logic [31:0] idle_ftw;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed ftw=%h stb/busy/done=%b required ftw=%h stb/busy/done=%b",
             tag, obs[34:3], obs[2:0], exp[34:3], exp[2:0]);
    end
  endtask

  function automatic logic [34:0] outs();
    return {bus.ftw_out, bus.step_stb, bus.busy, bus.done};
  endfunction

  // Expected {ftw, step_stb, busy, done} in output cycle c (c=1 is the cycle after start).
  function automatic logic [34:0] model(input int c);
    int n, k, idx, p, cend;
    logic [31:0] w;
    k = (c - 1) % m_d;
    n = (c - 1) / m_d;
    if (m_mode == 1 || m_mode == 2) begin
      if (m_n == 0) return {m_s, (c == 1), 1'b1, 1'b0};
      if (m_mode == 1) idx = n % (m_n + 1);
      else begin
        p   = n % (2 * m_n);
        idx = (p <= m_n) ? p : 2 * m_n - p;
      end
      w = m_s + 32'(idx) * m_st;
      return {w, (k == 0), 1'b1, 1'b0};
    end
    cend = (m_n + 1) * m_d;
    if (c <= cend) begin
      w = m_s + 32'(n) * m_st;
      return {w, (k == 0), 1'b1, 1'b0};
    end
    w = m_s + 32'(m_n) * m_st;
    if (c == cend + 1) return {w, 1'b0, 1'b0, 1'b1};
    return {w, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic run(input logic [1:0] md, input logic [31:0] s, input logic [31:0] st,
                     input int n, input int dw, input int ncyc, input int stop_at,
                     input int rst_at, input int junk_at, input string tag);
    logic [34:0] e;
    logic [31:0] fz;
    int ended;
    m_mode = (md == 2'd3) ? 0 : int'(md);
    m_s = s; m_st = st; m_n = n;
    m_d = (dw < MIN_DWELL) ? MIN_DWELL : dw;
    bus.mode = md; bus.start_ftw = s; bus.step_ftw = st;
    bus.num_steps = NSTEP_W'(n); bus.dwell = 20'(dw); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    // Config changes during the sweep must be ignored.
    bus.start_ftw = $urandom; bus.step_ftw = $urandom;
    bus.num_steps = NSTEP_W'($urandom); bus.dwell = 20'($urandom); bus.mode = 2'($urandom);
    ended = 0; fz = '0;
    for (int c = 1; c <= ncyc; c++) begin
      e = (ended == 0) ? model(c) : {fz, 3'b000};
      chk(tag, outs(), e);
      if (ended == 0) fz = e[34:3];
      bus.stop  = (c == stop_at);
      rst       = (c == rst_at);
      bus.start = (c == junk_at);
      if (c == stop_at && ended == 0) ended = 1;
      if (c == rst_at) begin ended = 2; fz = '0; end
      tick();
    end
    bus.stop = 1'b0; rst = 1'b0; bus.start = 1'b0;
    if (ended == 0) begin
      e = model(ncyc + 1);
      chk({tag, "_last"}, outs(), e);
      fz = e[34:3];
    end else begin
      chk({tag, "_last"}, outs(), {fz, 3'b000});
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk({tag, "_stopped"}, outs(), {fz, 3'b000});
    idle_ftw = fz;
  endtask

  initial begin
    int md, n, dw, d, ncyc, stop_at;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = '0; bus.start_ftw = '0;
    bus.step_ftw = '0; bus.num_steps = '0; bus.dwell = '0;
    rst = 1'b1;
    tick(); tick();
    chk("reset", outs(), 35'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", outs(), 35'd0);

    run(2'd0, 32'h1000, 32'h100, 3, 1000, 4005, 0, 0, 0, "single");
    run(2'd0, 32'hFFFF_FF00, 32'h200, 1, 10, 1325, 0, 0, 0, "clamp_wrap");
    run(2'd2, 32'h0, 32'h1, 2, 660, 4625, 0, 0, 0, "triangle");
    run(2'd1, $urandom, $urandom, 1, 700, 1600, 1500, 0, 30, "saw_stop");
    run(2'd0, $urandom, $urandom, 5, 800, 60, 0, 50, 20, "abort_rst");

    bus.start_ftw = $urandom; bus.mode = 2'd0; bus.num_steps = NSTEP_W'(2);
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_idle", outs(), {idle_ftw, 3'b000});
    tick();
    chk("start_stop_idle2", outs(), {idle_ftw, 3'b000});

    run(2'd0, $urandom, $urandom, 0, 0, 665, 0, 0, 0, "single_n0");
    run(2'd1, $urandom, $urandom, 0, 700, 1500, 0, 0, 0, "saw_n0");
    run(2'd2, $urandom, $urandom, 0, 661, 1400, 0, 0, 0, "tri_n0");
    run(2'd3, $urandom, $urandom, 1, 670, 1345, 0, 0, 0, "mode3_single");

    for (int i = 0; i < 4; i++) begin
      md = int'($urandom_range(0, 3));
      n  = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 900));
      d  = (dw < MIN_DWELL) ? MIN_DWELL : dw;
      ncyc = (md == 1 || md == 2) ? 2 * (n + 1) * d + 5 : (n + 1) * d + 3;
      stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ncyc - 2)) : 0;
      run(2'(md), $urandom, $urandom, n, dw, ncyc, stop_at, 0, 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
